// File: rtl/robo_atuador.sv
// Actuation stage behind the navigation FSM: turns one-hot level commands into
// timed wheel/arm sequences and reports busy, done and illegal-command status.
module robo_atuador #(
  parameter int T_AVANCO = 8,
  parameter int T_GIRO   = 6,
  parameter int T_BRACO  = 4,
  parameter int CW       = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic avancar,
  input  logic girar,
  input  logic remover,
  output logic motor_esq_fwd,
  output logic motor_esq_rev,
  output logic motor_dir_fwd,
  output logic motor_dir_rev,
  output logic braco,
  output logic ocupado,
  output logic concluido,
  output logic erro
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    AVANCA  = 3'd1,
    GIRA    = 3'd2,
    EXTENDE = 3'd3,
    RECOLHE = 3'd4,
    FALHA   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          concluido_q, concluido_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      count_q     <= '0;
      concluido_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      concluido_q <= concluido_d;
    end
  end

  // Commands are only looked at while idle; anything seen during an operation is dropped.
  always_comb begin
    state_d     = OCIOSO;
    count_d     = '0;
    concluido_d = 1'b0;
    case (state_q)
      OCIOSO: begin
        case ({avancar, girar, remover})
          3'b000: state_d = OCIOSO;
          3'b100: begin
            state_d = AVANCA;
            count_d = CW'(T_AVANCO - 1);
          end
          3'b010: begin
            state_d = GIRA;
            count_d = CW'(T_GIRO - 1);
          end
          3'b001: begin
            state_d = EXTENDE;
            count_d = CW'(T_BRACO - 1);
          end
          default: state_d = FALHA;
        endcase
      end
      AVANCA, GIRA, RECOLHE: begin
        if (count_q == '0) begin
          state_d     = OCIOSO;
          concluido_d = 1'b1;
        end else begin
          state_d = state_q;
          count_d = count_q - CW'(1);
        end
      end
      EXTENDE: begin
        if (count_q == '0) begin
          state_d = RECOLHE;
          count_d = CW'(T_BRACO - 1);
        end else begin
          state_d = EXTENDE;
          count_d = count_q - CW'(1);
        end
      end
      FALHA:   state_d = FALHA;
      default: state_d = OCIOSO;
    endcase
  end

  // Moore decode; each wheel has at most one direction active in any state.
  always_comb begin
    motor_esq_fwd = 1'b0;
    motor_esq_rev = 1'b0;
    motor_dir_fwd = 1'b0;
    motor_dir_rev = 1'b0;
    braco         = 1'b0;
    ocupado       = 1'b0;
    erro          = 1'b0;
    case (state_q)
      AVANCA: begin
        motor_esq_fwd = 1'b1;
        motor_dir_fwd = 1'b1;
        ocupado       = 1'b1;
      end
      GIRA: begin
        motor_esq_rev = 1'b1;
        motor_dir_fwd = 1'b1;
        ocupado       = 1'b1;
      end
      EXTENDE: begin
        braco   = 1'b1;
        ocupado = 1'b1;
      end
      RECOLHE: ocupado = 1'b1;
      FALHA: begin
        ocupado = 1'b1;
        erro    = 1'b1;
      end
      default: ocupado = 1'b0;
    endcase
  end

  assign concluido = concluido_q;

endmodule

// File: tb/tb_robo_atuador.sv
// Self-checking bench for robo_atuador: directed scenarios plus random commands,
// compared every cycle against an operation-level reference model.
module tb_robo_atuador;

  localparam int T_AVANCO = 8;
  localparam int T_GIRO   = 6;
  localparam int T_BRACO  = 4;
  localparam int CW       = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic avancar = 1'b0, girar = 1'b0, remover = 1'b0;
  logic motorEsqFwd, motorEsqRev, motorDirFwd, motorDirRev;
  logic braco, ocupado, concluido, erro;

  int checkCount = 0;
  int errCount   = 0;

  // Reference model state: operation kind, cycles left in it, fault and done flags.
  int   mMode  = 0;
  int   mRem   = 0;
  logic mFault = 1'b0;
  logic mDone  = 1'b0;

  robo_atuador #(
    .T_AVANCO(T_AVANCO), .T_GIRO(T_GIRO), .T_BRACO(T_BRACO), .CW(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .avancar(avancar), .girar(girar), .remover(remover),
    .motor_esq_fwd(motorEsqFwd), .motor_esq_rev(motorEsqRev),
    .motor_dir_fwd(motorDirFwd), .motor_dir_rev(motorDirRev),
    .braco(braco), .ocupado(ocupado), .concluido(concluido), .erro(erro)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] dutVector();
    return {motorEsqFwd, motorEsqRev, motorDirFwd, motorDirRev, braco, ocupado, concluido, erro};
  endfunction

  function automatic logic [7:0] modelVector();
    logic active;
    active = (mRem > 0);
    return {active && mMode == 1,
            active && mMode == 2,
            active && (mMode == 1 || mMode == 2),
            1'b0,
            active && mMode == 3 && mRem > T_BRACO,
            active || mFault,
            mDone,
            mFault};
  endfunction

  task automatic modelReset();
    mMode = 0; mRem = 0; mFault = 1'b0; mDone = 1'b0;
  endtask

  task automatic modelStep(input logic a, input logic g, input logic r);
    int n;
    n = int'(a) + int'(g) + int'(r);
    mDone = 1'b0;
    if (mFault) begin
      mFault = 1'b1;
    end else if (mRem > 0) begin
      mRem--;
      if (mRem == 0) mDone = 1'b1;
    end else if (n > 1) begin
      mFault = 1'b1;
    end else if (n == 1) begin
      if (a) begin mMode = 1; mRem = T_AVANCO; end
      else if (g) begin mMode = 2; mRem = T_GIRO; end
      else begin mMode = 3; mRem = 2 * T_BRACO; end
    end
  endtask

  // One clock: drive commands, let the edge happen, compare half a cycle later.
  task automatic applyStimulus(input string tag, input logic a, input logic g, input logic r);
    avancar = a; girar = g; remover = r;
    @(posedge clock);
    modelStep(a, g, r);
    @(negedge clock);
    checkOutput(tag, dutVector(), modelVector());
    checkOutput({tag, "_excl"}, {motorEsqFwd & motorEsqRev, motorDirFwd & motorDirRev}, 8'd0);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("reset", dutVector(), 8'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] rnd;
    @(negedge clock);
    applyReset();
    checkOutput("reset_idle", dutVector(), modelVector());

    // Single advance pulse, then idle long enough to see the done pulse.
    applyStimulus("adv", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus("adv", 1'b0, 1'b0, 1'b0);

    applyStimulus("rem", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus("rem", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) applyStimulus("gir_hold", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("gir_hold", 1'b0, 1'b0, 1'b0);

    applyStimulus("fault", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) applyStimulus("fault", 1'b0, 1'b0, 1'b0);
    checkOutput("fault_sticky", {ocupado, erro}, 8'b11);
    applyReset();

    // Commands glitching mid-advance must be ignored.
    applyStimulus("glitch", 1'b1, 1'b0, 1'b0);
    applyStimulus("glitch", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("glitch", 1'b0, i[0], ~i[0]);
    for (int i = 0; i < 4; i++) applyStimulus("glitch", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a turn.
    applyStimulus("async", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("async", 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    modelStep(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst", dutVector(), 8'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus("post_rst", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus("post_rst", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if (mFault && $urandom_range(0, 5) == 0) applyReset();
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: rnd = 3'b000;
        5, 6:          rnd = 3'b100;
        7, 8:          rnd = 3'b010;
        9, 10:         rnd = 3'b001;
        default:       rnd = 3'($urandom_range(0, 7));
      endcase
      applyStimulus("rand", rnd[2], rnd[1], rnd[0]);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
